// File: rtl/match_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : match_flow_sequencer
//  Purpose  : Per-frame match flow FSM: title, kickoff countdown, play,
//             goal pause, respawn and game-over handling with banners.
//  Revision : 1.0 - initial release
// ============================================================================
module match_flow_sequencer #(
    parameter int GOAL_PAUSE_FRAMES = 120,
    parameter int DIGIT_FRAMES      = 60,
    parameter int COUNTDOWN_START   = 3,
    parameter int OVER_MIN_FRAMES   = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       goal_scored,
    input  logic       left_goal,
    input  logic       game_over,
    input  logic       p1_wins,
    input  logic       start_btn,
    output logic       freeze,
    output logic       ball_respawn,
    output logic       serve_left,
    output logic       game_restart,
    output logic       banner_goal,
    output logic [1:0] banner_winner,
    output logic [3:0] countdown_digit,
    output logic [2:0] flow_state
);

    typedef enum logic [2:0] {
        ST_TITLE      = 3'd0,
        ST_RESTART    = 3'd1,
        ST_COUNTDOWN  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_GOAL_PAUSE = 3'd4,
        ST_RESPAWN    = 3'd5,
        ST_GAME_OVER  = 3'd6
    } state_t;

    localparam logic [9:0] c_GOAL_LAST  = 10'(GOAL_PAUSE_FRAMES - 1);
    localparam logic [9:0] c_DIGIT_LAST = 10'(DIGIT_FRAMES - 1);
    localparam logic [9:0] c_OVER_MIN   = 10'(OVER_MIN_FRAMES);
    localparam logic [3:0] c_CD_START   = 4'(COUNTDOWN_START);

    state_t     r_state;
    logic [9:0] r_timer;
    logic [3:0] r_digit;
    logic       r_goal_left_q;
    logic       r_winner_q;
    logic       r_start_prev;

    state_t     w_state_nxt;
    logic [9:0] w_timer_nxt;
    logic [3:0] w_digit_nxt;
    logic       w_goal_left_nxt;
    logic       w_winner_nxt;
    logic       w_start_edge;

    assign w_start_edge = start_btn & ~r_start_prev;

    always_comb begin
        w_state_nxt     = ST_TITLE;
        w_timer_nxt     = r_timer;
        w_digit_nxt     = r_digit;
        w_goal_left_nxt = r_goal_left_q;
        w_winner_nxt    = r_winner_q;
        case (r_state)
            ST_TITLE: begin
                w_timer_nxt = '0;
                w_state_nxt = w_start_edge ? ST_RESTART : ST_TITLE;
            end
            ST_RESTART, ST_RESPAWN: begin
                w_state_nxt = ST_COUNTDOWN;
                w_digit_nxt = c_CD_START;
                w_timer_nxt = '0;
            end
            ST_COUNTDOWN: begin
                w_state_nxt = ST_COUNTDOWN;
                if (r_timer == c_DIGIT_LAST) begin
                    w_timer_nxt = '0;
                    if (r_digit <= 4'd1) begin
                        w_state_nxt = ST_PLAY;
                        w_digit_nxt = '0;
                    end else begin
                        w_digit_nxt = r_digit - 4'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 10'd1;
                end
            end
            ST_PLAY: begin
                w_timer_nxt = '0;
                if (goal_scored) begin
                    w_state_nxt     = ST_GOAL_PAUSE;
                    w_goal_left_nxt = left_goal;
                end else if (game_over) begin
                    w_state_nxt  = ST_GAME_OVER;
                    w_winner_nxt = p1_wins;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_GOAL_PAUSE: begin
                w_state_nxt = ST_GOAL_PAUSE;
                if (r_timer == c_GOAL_LAST) begin
                    w_timer_nxt = '0;
                    if (game_over) begin
                        w_state_nxt  = ST_GAME_OVER;
                        w_winner_nxt = p1_wins;
                    end else begin
                        w_state_nxt = ST_RESPAWN;
                    end
                end else begin
                    w_timer_nxt = r_timer + 10'd1;
                end
            end
            ST_GAME_OVER: begin
                w_state_nxt = ST_GAME_OVER;
                // Timer only gates the start key, so it parks at the minimum.
                if (r_timer < c_OVER_MIN) begin
                    w_timer_nxt = r_timer + 10'd1;
                end else if (w_start_edge) begin
                    w_state_nxt = ST_RESTART;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_TITLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so they line up with r_state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state         <= ST_TITLE;
            r_timer         <= '0;
            r_digit         <= '0;
            r_goal_left_q   <= 1'b0;
            r_winner_q      <= 1'b0;
            r_start_prev    <= 1'b1;
            freeze          <= 1'b1;
            ball_respawn    <= 1'b0;
            serve_left      <= 1'b0;
            game_restart    <= 1'b0;
            banner_goal     <= 1'b0;
            banner_winner   <= 2'b11;
            countdown_digit <= '0;
            flow_state      <= ST_TITLE;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_digit         <= w_digit_nxt;
            r_goal_left_q   <= w_goal_left_nxt;
            r_winner_q      <= w_winner_nxt;
            r_start_prev    <= start_btn;
            freeze          <= (w_state_nxt != ST_PLAY);
            ball_respawn    <= (w_state_nxt == ST_RESTART) || (w_state_nxt == ST_RESPAWN);
            serve_left      <= (w_state_nxt == ST_RESPAWN) && w_goal_left_nxt;
            game_restart    <= (w_state_nxt == ST_RESTART);
            banner_goal     <= (w_state_nxt == ST_GOAL_PAUSE);
            countdown_digit <= (w_state_nxt == ST_COUNTDOWN) ? w_digit_nxt : 4'd0;
            flow_state      <= w_state_nxt;
            case (w_state_nxt)
                ST_TITLE:     banner_winner <= 2'b11;
                ST_GAME_OVER: banner_winner <= w_winner_nxt ? 2'b01 : 2'b10;
                default:      banner_winner <= 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_match_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_flow_sequencer
//  Purpose  : Directed self-checking bench for match_flow_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_match_flow_sequencer;

    logic       frame_clk;
    logic       Reset;
    logic       goal_scored, left_goal, game_over, p1_wins, start_btn;
    logic       freeze, ball_respawn, serve_left, game_restart, banner_goal;
    logic [1:0] banner_winner;
    logic [3:0] countdown_digit;
    logic [2:0] flow_state;
    logic [13:0] obs;
    int n_checks;
    int n_errors;

    match_flow_sequencer #(
        .GOAL_PAUSE_FRAMES(4),
        .DIGIT_FRAMES     (2),
        .COUNTDOWN_START  (3),
        .OVER_MIN_FRAMES  (3)
    ) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .goal_scored    (goal_scored),
        .left_goal      (left_goal),
        .game_over      (game_over),
        .p1_wins        (p1_wins),
        .start_btn      (start_btn),
        .freeze         (freeze),
        .ball_respawn   (ball_respawn),
        .serve_left     (serve_left),
        .game_restart   (game_restart),
        .banner_goal    (banner_goal),
        .banner_winner  (banner_winner),
        .countdown_digit(countdown_digit),
        .flow_state     (flow_state)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // {flow_state, freeze, ball_respawn, serve_left, game_restart, banner_goal, banner_winner, digit}
    assign obs = {flow_state, freeze, ball_respawn, serve_left, game_restart,
                  banner_goal, banner_winner, countdown_digit};

    function automatic logic [13:0] ex(input logic [2:0] st, input logic frz, input logic rsp,
                                       input logic sl, input logic rs, input logic bg,
                                       input logic [1:0] bw, input logic [3:0] dg);
        return {st, frz, rsp, sl, rs, bg, bw, dg};
    endfunction

    task automatic tick;
        @(negedge frame_clk);
    endtask

    task automatic test_reset;
        logic [13:0] e;
        Reset = 1'b1;
        tick; tick;
        e = ex(3'd0, 1, 0, 0, 0, 0, 2'b11, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL reset_state got=%h exp=%h", obs, e); end
        Reset = 1'b0;
    endtask

    task automatic test_start;
        logic [13:0] e;
        start_btn = 1'b0;
        tick;
        e = ex(3'd0, 1, 0, 0, 0, 0, 2'b11, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL title_idle got=%h exp=%h", obs, e); end
        start_btn = 1'b1;
        tick;
        e = ex(3'd1, 1, 1, 0, 1, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL restart got=%h exp=%h", obs, e); end
        start_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            e = ex(3'd2, 1, 0, 0, 0, 0, 2'b00, 4'(3 - i / 2));
            n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL countdown[%0d] got=%h exp=%h", i, obs, e); end
        end
        tick;
        e = ex(3'd3, 0, 0, 0, 0, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL play_entry got=%h exp=%h", obs, e); end
        tick;
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL play_hold got=%h exp=%h", obs, e); end
    endtask

    // Left goal, with stray goal pulses injected during the pause and countdown.
    task automatic test_goal_left;
        logic [13:0] e;
        goal_scored = 1'b1; left_goal = 1'b1;
        tick;
        goal_scored = 1'b0; left_goal = 1'b0;
        e = ex(3'd4, 1, 0, 0, 0, 1, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL goal_pause[0] got=%h exp=%h", obs, e); end
        for (int i = 1; i < 4; i++) begin
            goal_scored = (i == 1);
            tick;
            goal_scored = 1'b0;
            n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL goal_pause[%0d] got=%h exp=%h", i, obs, e); end
        end
        tick;
        e = ex(3'd5, 1, 1, 1, 0, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL respawn_left got=%h exp=%h", obs, e); end
        for (int i = 0; i < 6; i++) begin
            goal_scored = (i == 2);
            tick;
            goal_scored = 1'b0;
            e = ex(3'd2, 1, 0, 0, 0, 0, 2'b00, 4'(3 - i / 2));
            n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL goal_countdown[%0d] got=%h exp=%h", i, obs, e); end
        end
        tick;
        e = ex(3'd3, 0, 0, 0, 0, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL goal_replay got=%h exp=%h", obs, e); end
    endtask

    task automatic test_goal_game_over;
        logic [13:0] e;
        goal_scored = 1'b1; left_goal = 1'b0; game_over = 1'b1; p1_wins = 1'b1;
        tick;
        goal_scored = 1'b0;
        e = ex(3'd4, 1, 0, 0, 0, 1, 2'b00, 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL final_pause[%0d] got=%h exp=%h", i, obs, e); end
        end
        tick;
        e = ex(3'd6, 1, 0, 0, 0, 0, 2'b01, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_entry got=%h exp=%h", obs, e); end
        p1_wins = 1'b0;
        tick;
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_winner_latched got=%h exp=%h", obs, e); end
        start_btn = 1'b1;
        tick;
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_early_start got=%h exp=%h", obs, e); end
        start_btn = 1'b0;
        tick;
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_wait got=%h exp=%h", obs, e); end
        start_btn = 1'b1;
        tick;
        start_btn = 1'b0; game_over = 1'b0;
        e = ex(3'd1, 1, 1, 0, 1, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_restart got=%h exp=%h", obs, e); end
        for (int i = 0; i < 7; i++) tick;
        e = ex(3'd3, 0, 0, 0, 0, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_replay got=%h exp=%h", obs, e); end
        game_over = 1'b1; p1_wins = 1'b0;
        tick;
        game_over = 1'b0;
        e = ex(3'd6, 1, 0, 0, 0, 0, 2'b10, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL over_direct_p2 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_hold;
        logic [13:0] e;
        Reset = 1'b1; start_btn = 1'b1;
        tick;
        Reset = 1'b0;
        tick; tick;
        e = ex(3'd0, 1, 0, 0, 0, 0, 2'b11, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL held_start_title got=%h exp=%h", obs, e); end
        start_btn = 1'b0;
        tick;
        start_btn = 1'b1;
        tick;
        start_btn = 1'b0;
        e = ex(3'd1, 1, 1, 0, 1, 0, 2'b00, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL held_start_press got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid_countdown;
        logic [13:0] e;
        tick; tick; tick;
        e = ex(3'd2, 1, 0, 0, 0, 0, 2'b00, 4'd2);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL mid_countdown got=%h exp=%h", obs, e); end
        #2 Reset = 1'b1;
        #1;
        e = ex(3'd0, 1, 0, 0, 0, 0, 2'b11, 4'd0);
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
        tick;
        Reset = 1'b0;
        tick;
        n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL post_reset_title got=%h exp=%h", obs, e); end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        Reset = 1'b1; goal_scored = 1'b0; left_goal = 1'b0;
        game_over = 1'b0; p1_wins = 1'b0; start_btn = 1'b0;
        test_reset;
        test_start;
        test_goal_left;
        test_goal_game_over;
        test_reset_hold;
        test_reset_mid_countdown;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_flow_sequencer.md
Name: match_flow_sequencer

Overview:
- Consumes the goal detector's outputs: the `goal_scored` pulse, `left_goal`, `game_over` and `p1_wins`.
- Drives the rest of the match flow:
  - freezes players and ball during the post-goal pause and the kickoff countdown;
  - requests a ball respawn with a serve direction;
  - shows the goal and winner banners;
  - issues the `game_restart` pulse back to the goal detector when a player presses start.
- Sits between the goal detector, the ball/player motion blocks and the HUD/banner renderer; it advances once per frame on `frame_clk`.

Parameters:
- GOAL_PAUSE_FRAMES, 120, frames the goal banner is held after a goal (range 1..1023).
- DIGIT_FRAMES, 60, frames each countdown digit is shown (range 1..1023).
- COUNTDOWN_START, 3, first countdown digit (range 1..9).
- OVER_MIN_FRAMES, 60, frames in GAME_OVER during which start is ignored (range 0..1023).

Ports:
- frame_clk  in  1  frame clock; all state advances on its rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- goal_scored  in  1  one-frame pulse from the goal detector.
- left_goal  in  1  1 = ball entered the left goal (P2 scored); valid with `goal_scored`.
- game_over  in  1  level from the goal detector.
- p1_wins  in  1  valid while `game_over` = 1.
- start_btn  in  1  start key level, already synchronous to `frame_clk`.
- freeze  out  1  1 = motion blocks hold positions and ignore input.
- ball_respawn  out  1  one-frame pulse: place ball at centre, zero velocity.
- serve_left  out  1  serve direction for the respawn; valid while `ball_respawn` = 1.
- game_restart  out  1  one-frame pulse to the goal detector to clear scores.
- banner_goal  out  1  show the "GOAL" banner.
- banner_winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 title screen.
- countdown_digit  out  4  digit to display; 0 when no countdown is active.
- flow_state  out  3  current state encoding, for debug.

Behaviour:
- All outputs are registered (Moore) and decoded from the state and the latches.
- States and encodings:
  - TITLE = 0
  - RESTART = 1
  - COUNTDOWN = 2
  - PLAY = 3
  - GOAL_PAUSE = 4
  - RESPAWN = 5
  - GAME_OVER = 6
- Reset (asynchronous, applies mid-operation too):
  - state = TITLE, timer = 0;
  - `freeze` = 1, `banner_winner` = 11;
  - all pulses 0, `banner_goal` 0, `countdown_digit` 0, `serve_left` 0;
  - `start_prev` = 1, so a key held through reset does not start a game.
- Start edge: `start_edge` = `start_btn` & ~`start_prev`; `start_prev` updates every frame.
- TITLE: on `start_edge` → RESTART.
- RESTART (exactly 1 frame):
  - `game_restart` = 1, `ball_respawn` = 1, `serve_left` = 0, `freeze` = 1;
  - next state is COUNTDOWN with digit = COUNTDOWN_START and timer = 0.
- COUNTDOWN:
  - `freeze` = 1, `countdown_digit` = current digit;
  - timer increments each frame;
  - when timer = DIGIT_FRAMES-1: timer clears and digit decrements;
  - leaving digit 1 → PLAY.
  - Total duration is exactly COUNTDOWN_START×DIGIT_FRAMES frames.
- PLAY: `freeze` = 0. Evaluated in priority order:
  1. `goal_scored` = 1: latch `goal_left_q` = `left_goal` → GOAL_PAUSE, timer = 0.
  2. else `game_over` = 1 → GAME_OVER, timer = 0.
  3. else remain in PLAY.
- GOAL_PAUSE:
  - `freeze` = 1, `banner_goal` = 1; `goal_scored` is ignored;
  - on timer = GOAL_PAUSE_FRAMES-1, sample `game_over`:
    - 1 → GAME_OVER with timer = 0 and `winner_q` = `p1_wins`;
    - 0 → RESPAWN.
- RESPAWN (exactly 1 frame):
  - `ball_respawn` = 1, `serve_left` = `goal_left_q` (ball served toward the conceding player's side), `freeze` = 1;
  - → COUNTDOWN.
- GAME_OVER:
  - `freeze` = 1;
  - `banner_winner` = 01 if `winner_q`, else 10;
  - timer saturates at OVER_MIN_FRAMES;
  - `start_edge` while timer < OVER_MIN_FRAMES is ignored;
  - `start_edge` with timer ≥ OVER_MIN_FRAMES → RESTART.
  - On a direct PLAY → GAME_OVER transition, `winner_q` latches `p1_wins` on entry.
- `banner_winner` = 00 in every state except TITLE and GAME_OVER.
- `goal_scored` in any state other than PLAY: ignored, nothing latched.
- Pulse outputs (`game_restart`, `ball_respawn`) are never high for two consecutive frames.
- Timer: 10-bit unsigned and never wraps; it compares with equality except where saturation is stated above.
- Illegal `flow_state` encodings (7) → TITLE on the next edge.

Test Plan:
1. Parameters: GOAL_PAUSE_FRAMES=4, DIGIT_FRAMES=2, COUNTDOWN_START=3, OVER_MIN_FRAMES=3. Reset then `start_btn` rising → exactly 1 frame of `game_restart` = `ball_respawn` = 1, then `countdown_digit` shows 3,3,2,2,1,1, then PLAY with `freeze` = 0.
2. In PLAY, `goal_scored` = 1 with `left_goal` = 1 and `game_over` = 0 → `banner_goal` high for 4 frames, then 1 frame of `ball_respawn` = 1 with `serve_left` = 1, then 6 countdown frames, then PLAY.
3. `goal_scored` = 1 with `game_over` = 1 and `p1_wins` = 1 → 4 frames of `banner_goal`, then GAME_OVER with `banner_winner` = 01. A `start_edge` at GAME_OVER timer 1 is ignored; a `start_edge` at timer 3 → RESTART.
4. Hold `start_btn` = 1 through Reset deassertion → stays in TITLE. Release then press → RESTART.
5. Extra `goal_scored` pulses during GOAL_PAUSE and COUNTDOWN → no state change, `serve_left` unchanged.
6. Assert Reset mid-COUNTDOWN (digit 2) → immediately TITLE, `freeze` = 1, `countdown_digit` = 0, `banner_winner` = 11.
